// File: rtl/priority_encoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder_arbiter
// Brief    : Synchronises and stability-filters a request vector, then grants
//            one index (fixed MSB-first or round-robin) over valid/ack.
// Revision : 1.0 - initial release
// ============================================================================
module priority_encoder_arbiter #(
    parameter  int NUM_IN        = 18,
    parameter  int STABLE_CYCLES = 4,
    localparam int OUT_W         = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req_i,
    input  logic              mode_i,
    input  logic              ack_i,
    output logic [OUT_W-1:0]  index_o,
    output logic              valid_o,
    output logic              none_o,
    output logic              change_o
);

    localparam int                 c_cnt_w   = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_arm = c_cnt_w'(STABLE_CYCLES - 1);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_issue = 1'b1;

    logic [NUM_IN-1:0]  r_s1;
    logic [NUM_IN-1:0]  r_s2;
    logic [NUM_IN-1:0]  r_prev;
    logic [NUM_IN-1:0]  r_filt;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_change;
    logic               r_none;

    logic [0:0]         r_state;
    logic [OUT_W-1:0]   r_index;
    logic               r_valid;
    logic [OUT_W-1:0]   r_ptr;

    logic [0:0]         w_state_nxt;
    logic [OUT_W-1:0]   w_index_nxt;
    logic               w_valid_nxt;
    logic [OUT_W-1:0]   w_ptr_nxt;

    logic [OUT_W-1:0]   w_fix_idx;
    logic [OUT_W-1:0]   w_lo_idx;
    logic [OUT_W-1:0]   w_hi_idx;
    logic               w_lo_hit;
    logic [OUT_W-1:0]   w_sel;

    // Input synchroniser and stability filter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_prev   <= '0;
            r_filt   <= '0;
            r_cnt    <= '0;
            r_change <= 1'b0;
            r_none   <= 1'b1;
        end else begin
            r_s1     <= req_i;
            r_s2     <= r_s1;
            r_prev   <= r_s2;
            r_change <= 1'b0;
            r_none   <= (r_filt == '0);
            if (r_s2 != r_prev) begin
                r_cnt <= '0;
            end else begin
                if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
                if (r_cnt == c_cnt_arm) begin
                    r_filt   <= r_s2;
                    r_change <= (r_s2 != r_filt);
                end
            end
        end
    end

    // Ascending scan: last hit below ptr is the round-robin winner; last hit
    // at or above ptr is the wrap-around winner; last hit overall is fixed.
    always_comb begin
        w_fix_idx = '0;
        w_lo_idx  = '0;
        w_hi_idx  = '0;
        w_lo_hit  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_filt[i]) begin
                w_fix_idx = OUT_W'(i);
                if (OUT_W'(i) < r_ptr) begin
                    w_lo_idx = OUT_W'(i);
                    w_lo_hit = 1'b1;
                end else begin
                    w_hi_idx = OUT_W'(i);
                end
            end
        end
        if (!mode_i) begin
            w_sel = w_fix_idx;
        end else if (w_lo_hit) begin
            w_sel = w_lo_idx;
        end else begin
            w_sel = w_hi_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_index <= '1;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_valid <= w_valid_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Grant is frozen in ISSUE until acked; no revocation
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_valid_nxt = r_valid;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_idle: begin
                if (r_filt != '0) begin
                    w_index_nxt = w_sel;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = c_issue;
                end else begin
                    w_index_nxt = '1;
                    w_valid_nxt = 1'b0;
                end
            end
            c_issue: begin
                if (ack_i) begin
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_index;
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_index_nxt = '1;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign index_o  = r_index;
    assign valid_o  = r_valid;
    assign none_o   = r_none;
    assign change_o = r_change;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_encoder_arbiter
// Brief    : Directed scenarios plus randomized traffic against a
//            sample-history reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_arbiter;

    localparam int NUM_IN        = 18;
    localparam int STABLE_CYCLES = 4;
    localparam int OUT_W         = 5;
    localparam int HIST          = STABLE_CYCLES + 3;

    logic              clk    = 1'b0;
    logic              rst    = 1'b0;
    logic [NUM_IN-1:0] req_i  = '0;
    logic              mode_i = 1'b0;
    logic              ack_i  = 1'b0;
    logic [OUT_W-1:0]  index_o;
    logic              valid_o;
    logic              none_o;
    logic              change_o;

    int total = 0;
    int bad   = 0;

    priority_encoder_arbiter #(
        .NUM_IN        (NUM_IN),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .mode_i   (mode_i),
        .ack_i    (ack_i),
        .index_o  (index_o),
        .valid_o  (valid_o),
        .none_o   (none_o),
        .change_o (change_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: filt takes a value once it has been seen on
    // STABLE_CYCLES+1 consecutive samples, two samples back (synchroniser).
    logic [NUM_IN-1:0] hist [HIST];
    logic [NUM_IN-1:0] m_filt;
    logic [NUM_IN-1:0] m_nf;
    bit                m_valid;
    bit                m_none;
    bit                m_change;
    bit                m_same;
    int                m_index;
    int                m_ptr;
    bit                mon_en = 1'b0;

    function automatic int pick(input logic [NUM_IN-1:0] v, input bit rr, input int ptr);
        int idx;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = rr ? (ptr - k + NUM_IN) % NUM_IN : NUM_IN - k;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < HIST; j++) hist[j] = '0;
        m_filt   = '0;
        m_valid  = 1'b0;
        m_none   = 1'b1;
        m_change = 1'b0;
        m_index  = (1 << OUT_W) - 1;
        m_ptr    = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            if (!m_valid) begin
                if (m_filt != '0) begin
                    m_index = pick(m_filt, mode_i, m_ptr);
                    m_valid = 1'b1;
                end
            end else if (ack_i) begin
                m_valid = 1'b0;
                m_ptr   = m_index;
            end
            m_none = (m_filt == '0);
            for (int j = 0; j < HIST - 1; j++) hist[j] = hist[j+1];
            hist[HIST-1] = req_i;
            m_same = 1'b1;
            for (int j = 1; j <= STABLE_CYCLES; j++) begin
                if (hist[j] != hist[0]) m_same = 1'b0;
            end
            m_nf     = m_same ? hist[0] : m_filt;
            m_change = (m_nf != m_filt);
            m_filt   = m_nf;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check_eq("mon_valid", 32'(valid_o), 32'(m_valid));
            check_eq("mon_none", 32'(none_o), 32'(m_none));
            check_eq("mon_change", 32'(change_o), 32'(m_change));
            if (m_valid) check_eq("mon_index", 32'(index_o), 32'(m_index));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_index"}, 32'(index_o), 32'h1F);
        check_eq({tag, "_valid"}, 32'(valid_o), 32'h0);
        check_eq({tag, "_none"}, 32'(none_o), 32'h1);
        check_eq({tag, "_change"}, 32'(change_o), 32'h0);
    endtask

    int got_idx[$];
    int got_t[$];
    int t;

    initial begin
        model_reset();

        // Reset state, applied asynchronously before any edge
        #1 rst = 1'b1;
        #1 check_reset_outputs("t1_rst");
        tick(2);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(10);

        // Fixed priority latency, hold while unacked, ack and re-grant
        req_i = (NUM_IN'(1) << 9) | (NUM_IN'(1) << 3);
        tick(STABLE_CYCLES + 3);
        check_eq("t2_pre_valid", 32'(valid_o), 32'h0);
        check_eq("t2_change_pulse", 32'(change_o), 32'h1);
        tick(1);
        check_eq("t2_valid", 32'(valid_o), 32'h1);
        check_eq("t2_index", 32'(index_o), 32'd9);
        check_eq("t2_change_gone", 32'(change_o), 32'h0);
        tick(10);
        check_eq("t2_hold_index", 32'(index_o), 32'd9);
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        check_eq("t2_ack_drop", 32'(valid_o), 32'h0);
        tick(1);
        check_eq("t2_regrant", 32'(valid_o), 32'h1);
        check_eq("t2_regrant_idx", 32'(index_o), 32'd9);

        // Drain, then a short glitch must not reach the filter
        req_i = '0;
        ack_i = 1'b1;
        tick(14);
        ack_i = 1'b0;
        tick(2);
        check_eq("t3_idle_valid", 32'(valid_o), 32'h0);
        check_eq("t3_idle_none", 32'(none_o), 32'h1);
        req_i = NUM_IN'(1) << 5;
        tick(3);
        req_i = '0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check_eq("t3_glitch_change", 32'(change_o), 32'h0);
            check_eq("t3_glitch_valid", 32'(valid_o), 32'h0);
            check_eq("t3_glitch_none", 32'(none_o), 32'h1);
        end

        // Round-robin with ack tied high from a fresh pointer
        rst = 1'b1;
        tick(1);
        rst    = 1'b0;
        mode_i = 1'b1;
        ack_i  = 1'b1;
        req_i  = (NUM_IN'(1) << 17) | (NUM_IN'(1) << 9) | (NUM_IN'(1) << 3);
        for (t = 0; t < 40 && got_idx.size() < 5; t++) begin
            tick(1);
            if (valid_o) begin
                got_idx.push_back(int'(index_o));
                got_t.push_back(t);
            end
        end
        check_eq("t4_grant_count", 32'(got_idx.size()), 32'd5);
        if (got_idx.size() == 5) begin
            check_eq("t4_g0", 32'(got_idx[0]), 32'd17);
            check_eq("t4_g1", 32'(got_idx[1]), 32'd9);
            check_eq("t4_g2", 32'(got_idx[2]), 32'd3);
            check_eq("t4_g3", 32'(got_idx[3]), 32'd17);
            check_eq("t4_g4", 32'(got_idx[4]), 32'd9);
            for (int i = 1; i < 5; i++) check_eq("t4_spacing", 32'(got_t[i] - got_t[i-1]), 32'd2);
        end

        // No revocation; mode only matters at the idle decision
        ack_i = 1'b0;
        req_i = '0;
        rst   = 1'b1;
        tick(1);
        rst   = 1'b0;
        req_i = (NUM_IN'(1) << 9) | (NUM_IN'(1) << 3);
        tick(STABLE_CYCLES + 4);
        check_eq("t5_grant9", 32'(index_o), 32'd9);
        req_i = (NUM_IN'(1) << 12) | (NUM_IN'(1) << 9) | (NUM_IN'(1) << 3);
        tick(10);
        check_eq("t5_hold9_valid", 32'(valid_o), 32'h1);
        check_eq("t5_hold9_index", 32'(index_o), 32'd9);
        ack_i  = 1'b1;
        mode_i = 1'b0;
        tick(1);
        ack_i = 1'b0;
        check_eq("t5_ack_drop", 32'(valid_o), 32'h0);
        tick(1);
        check_eq("t5_grant12_valid", 32'(valid_o), 32'h1);
        check_eq("t5_grant12_index", 32'(index_o), 32'd12);

        // Asynchronous reset mid-ISSUE and full latency on recovery
        tick(2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("t6_rst");
        tick(2);
        rst = 1'b0;
        tick(STABLE_CYCLES + 3);
        check_eq("t6_pre_valid", 32'(valid_o), 32'h0);
        tick(1);
        check_eq("t6_valid", 32'(valid_o), 32'h1);
        check_eq("t6_index", 32'(index_o), 32'd12);

        // Randomized traffic against the model
        for (int blk = 0; blk < 120; blk++) begin
            case ($urandom_range(0, 3))
                0: req_i = '0;
                1: req_i = NUM_IN'($urandom);
                2: req_i = NUM_IN'(1) << $urandom_range(0, NUM_IN - 1);
                default: req_i = req_i ^ (NUM_IN'(1) << $urandom_range(0, NUM_IN - 1));
            endcase
            if ($urandom_range(0, 3) == 0) mode_i = ~mode_i;
            for (int c = $urandom_range(1, 9); c > 0; c--) begin
                ack_i = ($urandom_range(0, 2) == 0);
                tick(1);
            end
        end
        ack_i = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_encoder_arbiter.md
Name: priority_encoder_arbiter

Overview:
- Parametrised, clocked successor to the combinational switch priority encoder.
- Synchronises and stability-filters an N-bit request vector (switches or other asynchronous sources).
- Selects one active index by fixed MSB-first priority or by round-robin, and presents it with a valid/ack handshake.
- Sits between board-level inputs and display or control logic (e.g. seven-segment hex converter, LED drivers).

Parameters:
NUM_IN, 18, number of request inputs (2..32).
STABLE_CYCLES, 4, consecutive identical synchronised samples required before the filtered vector updates (>=1).
OUT_W, $clog2(NUM_IN), index width; derived, not overridden.

Ports:
Clock  input  1  system clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-high reset.
req_i  input  NUM_IN  raw asynchronous request vector.
mode_i  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
ack_i  input  1  consumer accepts the current grant.
index_o  output  OUT_W  granted index; all-ones when nothing is granted.
valid_o  output  1  index_o holds a grant awaiting ack.
none_o  output  1  filtered vector is all zero.
change_o  output  1  one-cycle pulse when the filtered vector changes value.

Behaviour:
- Reset (asynchronous, immediate, any state): sync flops, prev, filt, cnt and ptr = 0; FSM = IDLE; index_o = all-ones; valid_o = 0; none_o = 1; change_o = 0.
- Synchroniser: s1 <= req_i; s2 <= s1; prev <= s2.
- Stability counter cnt saturates at STABLE_CYCLES:
  - s2 != prev: cnt <= 0.
  - otherwise: cnt <= cnt+1 (saturating).
  - s2 == prev and cnt == STABLE_CYCLES-1: filt <= s2.
- change_o: registered pulse, 1 for exactly one cycle after filt is written with a value different from its previous value.
- none_o: registered; equals (filt == 0), so it lags filt by one cycle.
- Latency: count the first edge that samples a new req_i as edge 1.
  - filt updates on edge STABLE_CYCLES+3.
  - valid_o rises on edge STABLE_CYCLES+4, provided the FSM is in IDLE.
- Glitch rule: a req_i change lasting fewer than STABLE_CYCLES+1 sampled cycles never reaches filt.
- Grant selection (combinational from filt, mode_i, ptr; used only in IDLE):
  - mode_i=0: highest set bit of filt.
  - mode_i=1: search downward from ptr-1 to 0, then from NUM_IN-1 down to ptr inclusive. The first set bit wins. With ptr=0 this equals fixed priority.
- FSM:
  - IDLE:
    - filt == 0: stay in IDLE; index_o = all-ones; valid_o = 0.
    - filt != 0: index_o <= selected index; valid_o <= 1; go to ISSUE.
  - ISSUE:
    - index_o and valid_o held stable regardless of filt or mode_i changes.
    - ack_i=1: valid_o <= 0; ptr <= index_o (both modes); go to IDLE.
    - ack_i=0: stay in ISSUE.
  - ack_i is ignored in IDLE.
- Throughput: at most one grant every 2 cycles, i.e. valid_o deasserts for at least one cycle between grants.
- A granted bit that drops in filt while in ISSUE is still held until acked; no revocation.
- mode_i is sampled only in the IDLE decision cycle. ptr is retained across mode changes.
- Width rules: index_o values always < NUM_IN except the all-ones idle code. For NUM_IN equal to a power of two, the all-ones code aliases index NUM_IN-1; the consumer must qualify index_o with valid_o.

Test Plan:
1. Apply Reset with req_i=0 -> index_o=5'h1F, valid_o=0, none_o=1, change_o=0; assert Reset asynchronously between edges and check outputs clear before the next edge.
2. NUM_IN=18, STABLE_CYCLES=4, mode_i=0, ack_i=0, req_i bits {9,3} set -> change_o pulses once; valid_o=1 with index_o=9 on edge 8; index_o stays 9 for 10 unacked cycles; one-cycle ack -> valid_o=0 next edge, re-grant of 9 two edges after ack.
3. Bit 5 pulsed high for 3 cycles with req_i otherwise 0 -> filt unchanged, change_o never pulses, valid_o stays 0, none_o stays 1.
4. mode_i=1, req_i bits {17,9,3} stable, ack_i tied high -> grant sequence 17, 9, 3, 17, 9 at 2-cycle spacing.
5. While ISSUE holds index 9 unacked, raise bit 12 -> index_o stays 9; after ack, mode_i=0 -> next grant is 12.
6. Reset asserted mid-ISSUE, then released with req_i unchanged -> outputs at reset values; valid_o re-asserts only after the full STABLE_CYCLES+4 edge latency.
